// File: rtl/mapa_arbitro_if.sv
// Map write port bundle: snake/fruit request handshakes, clear request, storage write strobe.
interface mapa_arbitro_if;
    logic       limpar;
    logic       cobra_req;
    logic       cobra_dado;
    logic [9:0] cobra_x;
    logic [9:0] cobra_y;
    logic       cobra_ack;
    logic       fruta_req;
    logic       fruta_dado;
    logic [9:0] fruta_x;
    logic [9:0] fruta_y;
    logic       fruta_ack;
    logic       map_write;
    logic [9:0] map_x;
    logic [9:0] map_y;
    logic [1:0] map_dado;
    logic       ocupado;
    logic       erro_coord;

    modport master (
        output limpar, cobra_req, cobra_dado, cobra_x, cobra_y,
               fruta_req, fruta_dado, fruta_x, fruta_y,
        input  cobra_ack, fruta_ack, map_write, map_x, map_y, map_dado,
               ocupado, erro_coord
    );

    modport slave (
        input  limpar, cobra_req, cobra_dado, cobra_x, cobra_y,
               fruta_req, fruta_dado, fruta_x, fruta_y,
        output cobra_ack, fruta_ack, map_write, map_x, map_y, map_dado,
               ocupado, erro_coord
    );
endinterface

// File: rtl/mapa_arbitro.sv
// Round-robin arbiter for the map write port plus full-map clear sweep; 1-cycle req-to-write,
// requests simply wait (req held) while a sweep runs, each requester ineligible in its ack cycle.
module mapa_arbitro #(
    parameter int LARGURA = 80,
    parameter int ALTURA  = 60
) (
    input  logic          clk,
    input  logic          reset,
    mapa_arbitro_if.slave bus
);
    localparam logic [9:0] X_MAX = 10'(LARGURA - 1);
    localparam logic [9:0] Y_MAX = 10'(ALTURA - 1);
    localparam logic [9:0] X_LIM = 10'(LARGURA);
    localparam logic [9:0] Y_LIM = 10'(ALTURA);
    localparam logic [1:0] NADA  = 2'd0;
    localparam logic [1:0] COBRA = 2'd1;
    localparam logic [1:0] FRUTA = 2'd2;

    typedef enum logic {LIMPANDO, LIVRE} state_t;

    state_t     state_q, state_d;
    logic [9:0] cx_q, cx_d, cy_q, cy_d;
    logic       rr_q, rr_d;             // 1 = fruta served last
    logic       cobra_ack_q, cobra_ack_d;
    logic       fruta_ack_q, fruta_ack_d;
    logic       map_write_q, map_write_d;
    logic [9:0] map_x_q, map_x_d, map_y_q, map_y_d;
    logic [1:0] map_dado_q, map_dado_d;
    logic       ocupado_q, ocupado_d;
    logic       erro_q, erro_d;

    logic       cobra_eleg, fruta_eleg, gnt_cobra, gnt_fruta;
    logic [9:0] gx, gy;
    logic [1:0] gdado;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LIMPANDO;
            cx_q        <= '0;
            cy_q        <= '0;
            rr_q        <= 1'b1;
            cobra_ack_q <= 1'b0;
            fruta_ack_q <= 1'b0;
            map_write_q <= 1'b0;
            map_x_q     <= '0;
            map_y_q     <= '0;
            map_dado_q  <= NADA;
            ocupado_q   <= 1'b1;
            erro_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            rr_q        <= rr_d;
            cobra_ack_q <= cobra_ack_d;
            fruta_ack_q <= fruta_ack_d;
            map_write_q <= map_write_d;
            map_x_q     <= map_x_d;
            map_y_q     <= map_y_d;
            map_dado_q  <= map_dado_d;
            ocupado_q   <= ocupado_d;
            erro_q      <= erro_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        rr_d        = rr_q;
        cobra_ack_d = 1'b0;
        fruta_ack_d = 1'b0;
        map_write_d = 1'b0;
        map_x_d     = map_x_q;
        map_y_d     = map_y_q;
        map_dado_d  = map_dado_q;
        ocupado_d   = ocupado_q;
        erro_d      = 1'b0;

        // A req seen during its own ack still belongs to the transaction just consumed.
        cobra_eleg  = bus.cobra_req & ~cobra_ack_q;
        fruta_eleg  = bus.fruta_req & ~fruta_ack_q;
        gnt_cobra   = 1'b0;
        gnt_fruta   = 1'b0;
        gx          = bus.cobra_x;
        gy          = bus.cobra_y;
        gdado       = bus.cobra_dado ? COBRA : NADA;

        case (state_q)
            LIMPANDO: begin
                map_write_d = 1'b1;
                map_x_d     = cx_q;
                map_y_d     = cy_q;
                map_dado_d  = NADA;
                ocupado_d   = 1'b1;
                if (cx_q == X_MAX) begin
                    cx_d = '0;
                    if (cy_q == Y_MAX) begin
                        cy_d    = '0;
                        state_d = LIVRE;
                    end else begin
                        cy_d = cy_q + 10'd1;
                    end
                end else begin
                    cx_d = cx_q + 10'd1;
                end
            end
            default: begin
                ocupado_d = 1'b0;
                if (bus.limpar) begin
                    state_d   = LIMPANDO;
                    cx_d      = '0;
                    cy_d      = '0;
                    ocupado_d = 1'b1;
                end else begin
                    gnt_cobra = cobra_eleg & (~fruta_eleg | rr_q);
                    gnt_fruta = fruta_eleg & ~gnt_cobra;
                    if (gnt_fruta) begin
                        gx    = bus.fruta_x;
                        gy    = bus.fruta_y;
                        gdado = bus.fruta_dado ? FRUTA : NADA;
                    end
                    if (gnt_cobra || gnt_fruta) begin
                        rr_d        = gnt_fruta;
                        cobra_ack_d = gnt_cobra;
                        fruta_ack_d = gnt_fruta;
                        if (gx >= X_LIM || gy >= Y_LIM) begin
                            erro_d = 1'b1;
                        end else begin
                            map_write_d = 1'b1;
                            map_x_d     = gx;
                            map_y_d     = gy;
                            map_dado_d  = gdado;
                        end
                    end
                end
            end
        endcase
    end

    assign bus.cobra_ack  = cobra_ack_q;
    assign bus.fruta_ack  = fruta_ack_q;
    assign bus.map_write  = map_write_q;
    assign bus.map_x      = map_x_q;
    assign bus.map_y      = map_y_q;
    assign bus.map_dado   = map_dado_q;
    assign bus.ocupado    = ocupado_q;
    assign bus.erro_coord = erro_q;
endmodule
